stream_rr_arbiter: RTL and testbench

- Shares one downstream valid/ready stream (e.g. a pipeline register stage or shared compute unit) among NUM_REQ upstream requesters.
- Grants are round-robin, one beat at a time.
- Output is registered through an internal two-entry skid stage, so no combinational path runs from out_ready to any in_ready.
- Each output beat carries the winning requester's index, so downstream logic can route responses back.

---
 rtl/stream_rr_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_stream_rr_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter that merges NUM_REQ valid/ready streams into one,
// with a two-entry skid stage on the output. Each output beat is tagged
// with the index of the requester that sent it.
// Optional build macro STREAM_ARB_LOCK_EN: once a requester is granted, it
// keeps the grant until it sends a beat with in_last set (packet lock).
module stream_rr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  localparam int unsigned ID_WIDTH  = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_REQ-1:0]            in_valid,
  input  logic [NUM_REQ-1:0]            in_last,
  output logic [NUM_REQ-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [ID_WIDTH-1:0]           out_id,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int unsigned EntryW = DATA_WIDTH + ID_WIDTH + 1;

  typedef enum logic [1:0] {StEmpty, StBusy, StFull} stage_state_e;

  stage_state_e          state_q, state_d;
  logic [EntryW-1:0]     main_q, main_d, buf_q, buf_d;
  logic                  stage_ready_q, out_valid_q;
  logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ID_WIDTH-1:0]   grant_id, next_id;
  logic                  grant_any;
  logic [NUM_REQ-1:0]    grant;
  logic [2*NUM_REQ-1:0]  valid_rot;
  logic [DATA_WIDTH-1:0] ins_data;
  logic                  ins_last;
  logic [EntryW-1:0]     ins_entry;
  logic                  insert, remove;

`ifdef STREAM_ARB_LOCK_EN
  logic                lock_q, lock_d;
  logic [ID_WIDTH-1:0] lock_id_q, lock_id_d;
`else
  logic unused_in_last;
  assign unused_in_last = ^in_last;
`endif

  // Rotate valids so bit 0 corresponds to the current priority pointer.
  assign valid_rot = {in_valid, in_valid} >> ptr_q;

  // Round-robin scan from ptr; the lock (if built in) overrides the scan.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        grant_any = 1'b1;
        grant_id  = ID_WIDTH'((32'(ptr_q) + 32'(k)) % NUM_REQ);
      end
    end
`ifdef STREAM_ARB_LOCK_EN
    if (lock_q) begin
      grant_any = 1'b1;
      grant_id  = lock_id_q;
    end
`endif
    // No beat may be accepted while reset is asserted.
    if (!rst_n) begin
      grant_any = 1'b0;
    end
  end

  assign grant    = grant_any ? (NUM_REQ'(1) << grant_id) : '0;
  assign in_ready = grant & {NUM_REQ{stage_ready_q}};
  assign insert   = |(in_valid & in_ready);
  assign remove   = out_valid_q & out_ready;
  assign next_id  = (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  // Select the granted requester's payload and last flag.
  always_comb begin
    ins_data = '0;
    ins_last = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_WIDTH'(i)) begin
        ins_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
`ifdef STREAM_ARB_LOCK_EN
        ins_last = in_last[i];
`endif
      end
    end
  end

  assign ins_entry = {ins_data, grant_id, ins_last};

  // Pointer and lock next-state.
  always_comb begin
    ptr_d = ptr_q;
`ifdef STREAM_ARB_LOCK_EN
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (insert) begin
      lock_d    = ~ins_last;
      lock_id_d = grant_id;
      if (ins_last) begin
        ptr_d = next_id;
      end
    end
`else
    if (insert) begin
      ptr_d = next_id;
    end
`endif
  end

  // Skid stage next-state: main feeds the output, buf absorbs one extra beat.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    buf_d   = buf_q;
    case (state_q)
      StEmpty: begin
        if (insert) begin
          main_d  = ins_entry;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (insert && remove) begin
          main_d = ins_entry;
        end else if (insert) begin
          buf_d   = ins_entry;
          state_d = StFull;
        end else if (remove) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (remove) begin
          main_d  = buf_q;
          state_d = StBusy;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // State registers; ready/valid are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StEmpty;
      main_q        <= '0;
      buf_q         <= '0;
      stage_ready_q <= 1'b1;
      out_valid_q   <= 1'b0;
      ptr_q         <= '0;
`ifdef STREAM_ARB_LOCK_EN
      lock_q        <= 1'b0;
      lock_id_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      main_q        <= main_d;
      buf_q         <= buf_d;
      stage_ready_q <= (state_d != StFull);
      out_valid_q   <= (state_d != StEmpty);
      ptr_q         <= ptr_d;
`ifdef STREAM_ARB_LOCK_EN
      lock_q        <= lock_d;
      lock_id_q     <= lock_id_d;
`endif
    end
  end

  assign out_data  = main_q[EntryW-1 -: DATA_WIDTH];
  assign out_id    = main_q[ID_WIDTH:1];
  assign out_last  = main_q[0];
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter (NUM_REQ=4, DATA_WIDTH=8), plus a
// short randomised scoreboard run. Requester i drives 16*i + cnt[i], where
// cnt[i] counts that requester's accepted beats.
module tb_stream_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_id;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;
  int cnt[4];
  int wait_cnt[4];
  logic [9:0] sb[$];

  stream_rr_arbiter #(
    .NUM_REQ   (4),
    .DATA_WIDTH(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_id   (out_id),
    .out_last (out_last),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_data();
    for (int i = 0; i < 4; i++) in_data[i*8 +: 8] = 8'(16 * i + cnt[i]);
  endtask

  // Advance one clock; returns 1 time unit after the rising edge.
  task automatic step();
    logic [3:0] hs;
    hs = in_valid & in_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (hs[i]) cnt[i]++;
    set_data();
  endtask

  task automatic check_beat(input string tag, input logic [1:0] id, input logic [7:0] data);
    check({tag, " valid"}, 32'(out_valid), 32'd1);
    check({tag, " id"}, 32'(out_id), 32'(id));
    check({tag, " data"}, 32'(out_data), 32'(data));
`ifndef STREAM_ARB_LOCK_EN
    check({tag, " last"}, 32'(out_last), 32'd1);
`endif
  endtask

  initial begin
    logic [1:0] exp_id [8];
    logic [7:0] exp_dat[8];
    logic [3:0] hs;
    logic [9:0] front;
    exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    exp_dat = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h01, 8'h11, 8'h21, 8'h31};
    for (int i = 0; i < 4; i++) begin
      cnt[i]      = 0;
      wait_cnt[i] = 0;
    end
    set_data();
    rst_n     = 1'b0;
    in_valid  = 4'b0000;
    in_last   = 4'b1111;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_data", 32'(out_data), 32'd0);
    check("rst out_id", 32'(out_id), 32'd0);
    check("rst out_last", 32'(out_last), 32'd0);
    check("rst in_ready idle", 32'(in_ready), 32'd0);
    in_valid = 4'b1111;
    #1;
    check("rst in_ready valid", 32'(in_ready), 32'd0);

    // Round-robin with all requesters valid
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("rr first ready", 32'(in_ready), 32'b0001);
    check("rr no early valid", 32'(out_valid), 32'd0);
    for (int k = 0; k < 8; k++) begin
      step();
      check_beat($sformatf("rr beat%0d", k), exp_id[k], exp_dat[k]);
    end
    in_valid = 4'b0000;
    #1;
    check("idle ready", 32'(in_ready), 32'd0);
    step();
    check("drain valid", 32'(out_valid), 32'd0);

    // Single requester, then wrap from ptr=3
    in_valid = 4'b0100;
    #1;
    check("single ready", 32'(in_ready), 32'b0100);
    step();
    check_beat("single", 2'd2, 8'h22);
    in_valid = 4'b0101;
    #1;
    check("wrap ready", 32'(in_ready), 32'b0001);
    step();
    check_beat("wrap", 2'd0, 8'h02);
    in_valid = 4'b0000;
    step();
    check("wrap drained", 32'(out_valid), 32'd0);

    // Backpressure: one extra beat absorbed, then in_ready stays low
    in_valid = 4'b1111;
    #1;
    check("bp ready1", 32'(in_ready), 32'b0010);
    step();
    check_beat("bp beat1", 2'd1, 8'h12);
    out_ready = 1'b0;
    #1;
    check("bp ready2", 32'(in_ready), 32'b0100);
    step();
    check("bp full ready", 32'(in_ready), 32'd0);
    check_beat("bp hold", 2'd1, 8'h12);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("bp stall%0d ready", k), 32'(in_ready), 32'd0);
      check_beat($sformatf("bp stall%0d", k), 2'd1, 8'h12);
    end
    out_ready = 1'b1;
    #1;
    check("bp release ready", 32'(in_ready), 32'd0);
    step();
    check_beat("bp beat2", 2'd2, 8'h23);
    check("bp reopen ready", 32'(in_ready), 32'b1000);
    in_valid = 4'b0000;
    step();
    check("bp drained", 32'(out_valid), 32'd0);

    // Asynchronous reset with the stage full
    in_valid = 4'b1111;
    #1;
    check("ar ready", 32'(in_ready), 32'b1000);
    step();
    check_beat("ar beat1", 2'd3, 8'h32);
    out_ready = 1'b0;
    step();
    check("ar full ready", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("ar out_valid", 32'(out_valid), 32'd0);
    check("ar in_ready", 32'(in_ready), 32'd0);
    check("ar out_data", 32'(out_data), 32'd0);
    check("ar out_id", 32'(out_id), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("ar post ready", 32'(in_ready), 32'b0001);
    step();
    check_beat("ar post beat", 2'd0, 8'h04);
    in_valid = 4'b0000;
    step();

    // Randomised stress with scoreboard and starvation bound
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 4; i++)
        if (!in_valid[i]) in_valid[i] = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      check("st onehot", 32'($onehot0(in_ready)), 32'd1);
      hs = in_valid & in_ready;
      for (int g = 0; g < 4; g++) begin
        if (hs[g]) begin
          sb.push_back({2'(g), in_data[g*8 +: 8]});
          check("st starve", 32'(wait_cnt[g] <= 3), 32'd1);
          wait_cnt[g] = 0;
          for (int i = 0; i < 4; i++) if (i != g && in_valid[i]) wait_cnt[i]++;
        end
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("st spurious beat", 32'(out_valid), 32'd0);
        end else begin
          front = sb.pop_front();
          check("st order", 32'({out_id, out_data}), 32'(front));
        end
      end
      step();
      in_valid = in_valid & ~hs;
    end
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("st drain spurious", 32'(out_valid), 32'd0);
        end else begin
          front = sb.pop_front();
          check("st drain order", 32'({out_id, out_data}), 32'(front));
        end
      end
      step();
    end
    check("st lossless", 32'(sb.size()), 32'd0);

`ifdef STREAM_ARB_LOCK_EN
    // Packet lock: requester 1 holds the grant across a valid gap
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    set_data();
    in_last  = 4'b0000;
    in_valid = 4'b0110;
    #1;
    check("lk ready1", 32'(in_ready), 32'b0010);
    step();
    check("lk id1", 32'(out_id), 32'd1);
    check("lk last1", 32'(out_last), 32'd0);
    in_valid = 4'b0111;
    #1;
    check("lk ready2", 32'(in_ready), 32'b0010);
    step();
    check("lk id2", 32'(out_id), 32'd1);
    in_valid = 4'b0101;
    #1;
    check("lk gap ready", 32'(in_ready), 32'b0010);
    step();
    check("lk gap valid", 32'(out_valid), 32'd0);
    in_valid = 4'b0111;
    in_last  = 4'b0010;
    #1;
    check("lk ready3", 32'(in_ready), 32'b0010);
    step();
    check("lk id3", 32'(out_id), 32'd1);
    check("lk last3", 32'(out_last), 32'd1);
    check("lk next ready", 32'(in_ready), 32'b0100);
    step();
    check("lk next id", 32'(out_id), 32'd2);
    in_valid = 4'b0000;
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
